// File: rtl/arb_client.sv
// arb_client: a single requester in front of a fixed-priority arbiter.
// It accepts one burst command at a time. While it is busy it holds a
// request, and it emits one data beat for every cycle in which it is
// granted. Grant loss pauses the burst and never aborts it. If the
// request waits too long for a first grant, a starvation flag is raised.
module arb_client #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              starve_o
);

    // Wait counter only needs to count up to TIMEOUT and then saturate.
    localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [WC_W-1:0]   r_wcnt;
    logic              r_req;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_starve;

    logic              w_accept;
    logic              w_active;
    logic              w_beat;
    logic              w_is_last;
    logic [DATA_W-1:0] w_beat_data;
    logic [WC_W-1:0]   w_wcnt_nxt;

    // Beat data is base + beat index. The carry out of DATA_W is dropped,
    // so the value wraps silently.
    function automatic logic [DATA_W-1:0] beat_value(
        input logic [DATA_W-1:0] base,
        input logic [LEN_W-1:0]  k
    );
        logic [DATA_W+LEN_W-1:0] sum;
        sum = {{LEN_W{1'b0}}, base} + {{DATA_W{1'b0}}, k};
        return sum[DATA_W-1:0];
    endfunction

    // Wait counter next value. It holds at TIMEOUT instead of wrapping.
    function automatic logic [WC_W-1:0] wcnt_step(input logic [WC_W-1:0] cnt);
        return (cnt == WC_MAX) ? WC_MAX : cnt + WC_ONE;
    endfunction

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign w_accept    = cmd_valid_i & cmd_ready_o;
    assign w_active    = (r_state == S_WAIT) || (r_state == S_XFER);
    // Grants seen in IDLE are the arbiter's late response to a dropped request.
    assign w_beat      = w_active & gnt_i;
    assign w_is_last   = (r_cnt == r_len);
    assign w_beat_data = beat_value(r_base, r_cnt);
    assign w_wcnt_nxt  = wcnt_step(r_wcnt);

    assign req_o       = r_req;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign starve_o    = r_starve;

    // Burst FSM. It owns the command latch, the counters and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_wcnt      <= '0;
            r_req       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_starve    <= 1'b0;
        end else begin
            // Strobes are single-cycle. They are raised again only by a beat.
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_base  <= cmd_data_i;
                        r_len   <= cmd_len_i;
                        r_cnt   <= '0;
                        r_wcnt  <= '0;
                        r_req   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT, S_XFER: begin
                    if (w_beat) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_beat_data;
                        r_out_last  <= w_is_last;
                        r_cnt       <= r_cnt + LEN_ONE;
                        r_starve    <= 1'b0;
                        if (w_is_last) begin
                            // Dropping the request here leaves at least one
                            // low cycle before the next burst can request.
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_XFER;
                        end
                    end else if (r_state == S_WAIT) begin
                        // Starvation is measured only before the first beat.
                        // Once in XFER, a paused grant is not counted.
                        r_wcnt <= w_wcnt_nxt;
                        if (w_wcnt_nxt == WC_MAX) begin
                            r_starve <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_client.sv
// Directed bench for arb_client with the default parameters
// (DATA_W=8, LEN_W=4, TIMEOUT=15).
module tb_arb_client;

    logic       clk;
    logic       rst;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i;
    logic [3:0] cmd_len_i;
    logic       req_o;
    logic       gnt_i;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       out_last_o;
    logic       busy_o;
    logic       starve_o;

    int total;
    int bad;

    arb_client #(
        .DATA_W (8),
        .LEN_W  (4),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_data_i (cmd_data_i),
        .cmd_len_i  (cmd_len_i),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .busy_o     (busy_o),
        .starve_o   (starve_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check that the outputs show no beat, with the given request and busy levels.
    task automatic chk_idle_beat(input string tag, input logic exp_req, input logic exp_busy);
        chk({tag, ".valid"}, 32'(out_valid_o), 32'(1'b0));
        chk({tag, ".last"},  32'(out_last_o),  32'(1'b0));
        chk({tag, ".req"},   32'(req_o),       32'(exp_req));
        chk({tag, ".busy"},  32'(busy_o),      32'(exp_busy));
    endtask

    // Check that the outputs show one beat with the expected data and last flag.
    task automatic chk_beat(input string tag, input logic [7:0] exp_data, input logic exp_last);
        chk({tag, ".valid"}, 32'(out_valid_o), 32'(1'b1));
        chk({tag, ".data"},  32'(out_data_o),  32'(exp_data));
        chk({tag, ".last"},  32'(out_last_o),  32'(exp_last));
    endtask

    // Offer one command for a single cycle. It is accepted because the DUT is idle.
    task automatic issue(input logic [7:0] d, input logic [3:0] l);
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        cmd_len_i   = l;
        step();
        cmd_valid_i = 1'b0;
        cmd_data_i  = 8'h00;
        cmd_len_i   = 4'h0;
    endtask

    initial begin
        logic [7:0] e;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_data_i  = 8'h00;
        cmd_len_i   = 4'h0;
        gnt_i       = 1'b1;    // a grant during reset must be ignored

        // ---- reset state
        step();
        step();
        rst   = 1'b0;
        gnt_i = 1'b0;
        chk_idle_beat("rst", 1'b0, 1'b0);
        chk("rst.data",   32'(out_data_o),  32'h00);
        chk("rst.starve", 32'(starve_o),    32'(1'b0));
        chk("rst.ready",  32'(cmd_ready_o), 32'(1'b1));

        // ---- single beat 0x10, then a late grant in IDLE
        issue(8'h10, 4'h0);
        chk_idle_beat("single.wait", 1'b1, 1'b1);
        chk("single.ready", 32'(cmd_ready_o), 32'(1'b0));
        gnt_i = 1'b1;
        step();
        chk_beat("single.b0", 8'h10, 1'b1);
        chk("single.req_drop", 32'(req_o),       32'(1'b0));
        chk("single.ready_up", 32'(cmd_ready_o), 32'(1'b1));
        step();                                   // grant still high: late grant
        gnt_i = 1'b0;
        chk_idle_beat("late_gnt", 1'b0, 1'b0);

        // ---- burst 0xFE len 3 with the grant held, wraps through 0x00
        issue(8'hFE, 4'h3);
        gnt_i = 1'b1;
        step(); chk_beat("burst.b0", 8'hFE, 1'b0); chk("burst.req0", 32'(req_o), 32'(1'b1));
        step(); chk_beat("burst.b1", 8'hFF, 1'b0);
        step(); chk_beat("burst.b2", 8'h00, 1'b0);
        step(); chk_beat("burst.b3", 8'h01, 1'b1); chk("burst.req_drop", 32'(req_o), 32'(1'b0));
        step();
        gnt_i = 1'b0;
        chk_idle_beat("burst.after", 1'b0, 1'b0);

        // ---- grant loss after beat 1. Another command is offered meanwhile and must be ignored.
        issue(8'h20, 4'h3);
        gnt_i = 1'b1;
        step(); chk_beat("loss.b0", 8'h20, 1'b0);
        step(); chk_beat("loss.b1", 8'h21, 1'b0);
        gnt_i       = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h99;
        cmd_len_i   = 4'h0;
        step(); chk_idle_beat("loss.gap0", 1'b1, 1'b1); chk("loss.starve", 32'(starve_o), 32'(1'b0));
        step(); chk_idle_beat("loss.gap1", 1'b1, 1'b1);
        cmd_valid_i = 1'b0;
        gnt_i       = 1'b1;
        step(); chk_beat("loss.b2", 8'h22, 1'b0);
        step(); chk_beat("loss.b3", 8'h23, 1'b1);
        step();
        gnt_i = 1'b0;
        chk_idle_beat("loss.after", 1'b0, 1'b0);

        // ---- starvation: 20 WAIT cycles without a grant
        issue(8'h40, 4'h1);
        chk("starve.w1", 32'(starve_o), 32'(1'b0));
        for (int i = 1; i <= 20; i++) begin
            step();
            // The sample taken after edge i falls in WAIT cycle i+1.
            chk($sformatf("starve.w%0d", i + 1), 32'(starve_o), 32'(i >= 15));
            chk($sformatf("starve.v%0d", i + 1), 32'(out_valid_o), 32'(1'b0));
        end
        gnt_i = 1'b1;
        step(); chk_beat("starve.b0", 8'h40, 1'b0); chk("starve.clear", 32'(starve_o), 32'(1'b0));
        step(); chk_beat("starve.b1", 8'h41, 1'b1);
        step();
        gnt_i = 1'b0;
        chk_idle_beat("starve.after", 1'b0, 1'b0);

        // ---- maximum burst: 16 beats from 0xF8, wrapping through 0x00
        issue(8'hF8, 4'hF);
        gnt_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            e = 8'hF8 + 8'(k);
            chk_beat($sformatf("max.b%0d", k), e, (k == 15));
        end
        step();
        gnt_i = 1'b0;
        chk_idle_beat("max.after", 1'b0, 1'b0);

        // ---- reset asserted at beat 2 of a len=7 burst
        issue(8'h80, 4'h7);
        gnt_i = 1'b1;
        step(); chk_beat("rstmid.b0", 8'h80, 1'b0);
        step(); chk_beat("rstmid.b1", 8'h81, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_beat("rstmid.rst", 1'b0, 1'b0);
        chk("rstmid.data",   32'(out_data_o),  32'h00);
        chk("rstmid.ready",  32'(cmd_ready_o), 32'(1'b1));
        chk("rstmid.starve", 32'(starve_o),    32'(1'b0));
        step(); chk_idle_beat("rstmid.post0", 1'b0, 1'b0);
        step(); chk_idle_beat("rstmid.post1", 1'b0, 1'b0);
        gnt_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_client.md
ARB_CLIENT -- requirements
Module: arb_client

Interface
REQ-001 Parameter DATA_W, default 8, width of transfer data beats.
REQ-002 Parameter LEN_W, default 4, width of burst-length field; burst = cmd_len_i+1 beats (1..2^LEN_W).
REQ-003 Parameter TIMEOUT, default 15, WAIT cycles without grant before starvation flag.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid_i  input  1  command offered.
REQ-007 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-008 cmd_data_i  input  DATA_W  base data value of burst.
REQ-009 cmd_len_i  input  LEN_W  burst length minus one.
REQ-010 req_o  output  1  registered request to fixed-priority arbiter port.
REQ-011 gnt_i  input  1  grant bit for this port from arbiter (registered, one-hot across ports).
REQ-012 out_valid_o  output  1  registered beat strobe.
REQ-013 out_data_o  output  DATA_W  registered beat data.
REQ-014 out_last_o  output  1  registered, high with final beat of burst.
REQ-015 busy_o  output  1  high whenever state is not IDLE.
REQ-016 starve_o  output  1  registered starvation flag.

Function
REQ-017 FSM states IDLE, WAIT, XFER; IDLE = no command, WAIT = requesting, no beat yet, XFER = at least one beat issued.
REQ-018 cmd_ready_o SHALL equal (state==IDLE), combinational from state only.
REQ-019 IDLE: on cmd_valid_i&cmd_ready_o latch cmd_data_i, cmd_len_i; clear beat counter and wait counter; go WAIT; req_o=1 from next cycle.
REQ-020 Beat issue: any cycle in WAIT or XFER with gnt_i=1 issues beat k (k = beat counter), out_valid_o=1 and out_data_o=(base+k) mod 2^DATA_W on next cycle; counter increments.
REQ-021 WAIT with gnt_i=1 -> XFER (or IDLE if single-beat burst); WAIT with gnt_i=0 stays WAIT.
REQ-022 XFER with gnt_i=0: no beat, out_valid_o=0, counter holds, req_o held high, state holds (grant loss pauses, never aborts).
REQ-023 Beat with k==latched len SHALL set out_last_o=1 with it; state -> IDLE; req_o=0 from next cycle.
REQ-024 gnt_i in IDLE SHALL be ignored (covers the arbiter's one-cycle-late grant after req_o drops); no beat, no state change.
REQ-025 New command accepted no earlier than the cycle after last beat issue (cmd_ready_o rises with IDLE); back-to-back bursts thus separated by ≥1 req_o-low cycle.
REQ-026 Wait counter increments each WAIT cycle with gnt_i=0, saturates at TIMEOUT; starve_o=1 on the cycle after counter reaches TIMEOUT.
REQ-027 starve_o SHALL clear on the cycle after first beat issue; counter not active in XFER or IDLE.
REQ-028 out_valid_o, out_last_o SHALL be 0 in every cycle not following a beat issue.
REQ-029 Data wrap: base+k overflow wraps modulo 2^DATA_W, no flag.
REQ-030 Max burst 2^LEN_W beats; beat counter LEN_W bits, never wraps within a burst.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, req_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, starve_o=0, counters 0.
REQ-032 busy_o=0, cmd_ready_o=1 in cycle after reset.
REQ-033 Reset mid-WAIT or mid-XFER SHALL discard the latched command; no further beats; gnt_i during reset ignored.

Verification
REQ-034 Single beat: cmd data=0x10 len=0, gnt_i high 1 cycle after req_o -> one beat 0x10 with out_last_o=1, req_o low next cycle.
REQ-035 Burst: data=0xFE len=3, gnt_i held -> beats 0xFE,0xFF,0x00,0x01 on consecutive cycles, last on 0x01.
REQ-036 Grant loss: len=3, gnt_i dropped 2 cycles after beat 1 -> out_valid_o low 2 cycles, resume with beat 2, total 4 beats.
REQ-037 Starvation: TIMEOUT=15, gnt_i held low 20 cycles -> starve_o high from WAIT cycle 16, clears cycle after first beat.
REQ-038 Late grant: gnt_i high one cycle after last beat while IDLE -> no out_valid_o, state stays IDLE.
REQ-039 Reset mid-burst: rst at beat 2 of len=7 -> all outputs 0 next cycle, cmd_ready_o=1, no further beats.
